// File: rtl/halt_sequencer.sv
// Debug halt / memory wait-state / single-step sequencer driving the CPU clock gate.
// All outputs come straight from flops so halt never changes away from posedge.
module halt_sequencer #(
    parameter int WAIT_CYCLES = 2,
    parameter int STEP_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       dbg_halt_req,
    input  logic       dbg_resume_req,
    input  logic       dbg_step_req,
    input  logic       core_wfi,
    input  logic       irq_pending,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       halt,
    output logic       halted,
    output logic       step_done,
    output logic [1:0] state
);
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        HALTED   = 2'b10,
        STEP     = 2'b11
    } state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
    localparam logic [3:0] STEP_LD = 4'(STEP_CYCLES);
    localparam bit         WAIT_EN = (WAIT_CYCLES > 0);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [3:0] step_cnt_q, step_cnt_d;
    logic       wfi_wait_q, wfi_wait_d;
    logic       halt_pending_q, halt_pending_d;
    logic       step_return_q, step_return_d;
    logic       step_done_q, step_done_d;
    logic       halt_q, halted_q;

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        step_cnt_d     = step_cnt_q;
        wfi_wait_d     = wfi_wait_q;
        halt_pending_d = halt_pending_q;
        step_return_d  = step_return_q;
        step_done_d    = 1'b0;
        case (state_q)
            RUN: begin
                if (dbg_halt_req) begin
                    state_d = HALTED;
                end else if (core_wfi && !irq_pending) begin
                    state_d    = HALTED;
                    wfi_wait_d = 1'b1;
                end else if (mem_req && WAIT_EN) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_LD;
                end
            end
            MEM_WAIT: begin
                if (dbg_halt_req) halt_pending_d = 1'b1;
                if (wait_cnt_q != 4'd0) wait_cnt_d = wait_cnt_q - 4'd1;
                // Exit on the cycle the counter would reach zero, or early on mem_ready.
                if (wait_cnt_q <= 4'd1 || mem_ready) begin
                    wait_cnt_d     = 4'd0;
                    halt_pending_d = 1'b0;
                    step_return_d  = 1'b0;
                    if (halt_pending_q || dbg_halt_req) begin
                        state_d = HALTED;
                    end else if (step_return_q) begin
                        state_d     = HALTED;
                        step_done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            HALTED: begin
                if (dbg_halt_req) wfi_wait_d = 1'b0;
                if (dbg_resume_req) begin
                    state_d    = RUN;
                    wfi_wait_d = 1'b0;
                end else if (dbg_step_req) begin
                    state_d    = STEP;
                    step_cnt_d = STEP_LD;
                end else if (wfi_wait_q && irq_pending && !dbg_halt_req) begin
                    state_d    = RUN;
                    wfi_wait_d = 1'b0;
                end
            end
            STEP: begin
                if (mem_req && WAIT_EN) begin
                    state_d       = MEM_WAIT;
                    wait_cnt_d    = WAIT_LD;
                    step_return_d = 1'b1;
                    step_cnt_d    = 4'd0;
                end else begin
                    if (step_cnt_q != 4'd0) step_cnt_d = step_cnt_q - 4'd1;
                    if (step_cnt_q <= 4'd1) begin
                        state_d     = HALTED;
                        step_done_d = 1'b1;
                        step_cnt_d  = 4'd0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= RUN;
            wait_cnt_q     <= 4'd0;
            step_cnt_q     <= 4'd0;
            wfi_wait_q     <= 1'b0;
            halt_pending_q <= 1'b0;
            step_return_q  <= 1'b0;
            step_done_q    <= 1'b0;
            halt_q         <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            step_cnt_q     <= step_cnt_d;
            wfi_wait_q     <= wfi_wait_d;
            halt_pending_q <= halt_pending_d;
            step_return_q  <= step_return_d;
            step_done_q    <= step_done_d;
            halt_q         <= (state_d == MEM_WAIT) || (state_d == HALTED);
            halted_q       <= (state_d == HALTED);
        end
    end

    assign halt      = halt_q;
    assign halted    = halted_q;
    assign step_done = step_done_q;
    assign state     = state_q;
endmodule

// File: doc/halt_sequencer.md
HALT_SEQUENCER -- requirements
Module: halt_sequencer

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: memory wait-state stall length in clock cycles, range 0-15.
REQ-002 Parameter STEP_CYCLES, default 1: un-halted cycles granted per debug step, range 1-15.
REQ-003 clock  input  1  single system clock; all state updates on posedge clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 dbg_halt_req  input  1  debug halt request, one-cycle pulse.
REQ-006 dbg_resume_req  input  1  debug resume request, one-cycle pulse.
REQ-007 dbg_step_req  input  1  debug single-step request, one-cycle pulse.
REQ-008 core_wfi  input  1  core executed WFI, one-cycle pulse.
REQ-009 irq_pending  input  1  level, interrupt pending; wakes from WFI.
REQ-010 mem_req  input  1  core issued memory access, one-cycle pulse.
REQ-011 mem_ready  input  1  memory early-completion strobe.
REQ-012 halt  output  1  registered halt to the CPU clock gate; 1 = gate cpu_clock.
REQ-013 halted  output  1  registered, 1 while in HALTED.
REQ-014 step_done  output  1  registered one-cycle pulse at step completion.
REQ-015 state  output  2  current state encoding, for debug visibility.

Function
REQ-016 States: RUN=2'b00, MEM_WAIT=2'b01, HALTED=2'b10, STEP=2'b11; all outputs registered, changing only on posedge clock, so halt is stable across every negedge.
REQ-017 halt = 1 in MEM_WAIT and HALTED; halt = 0 in RUN and STEP.
REQ-018 RUN priority, highest first: dbg_halt_req -> HALTED; core_wfi with irq_pending=0 -> HALTED, set wfi_wait; mem_req with WAIT_CYCLES>0 -> MEM_WAIT, load wait counter = WAIT_CYCLES; else stay.
REQ-019 core_wfi with irq_pending=1 in the same cycle: no transition (WFI is a no-op).
REQ-020 mem_req with WAIT_CYCLES=0: ignored, no stall.
REQ-021 MEM_WAIT: wait counter decrements by 1 per cycle; exit when counter reaches 0 or mem_ready=1, whichever first; total halt length = WAIT_CYCLES cycles max, 1 cycle min.
REQ-022 MEM_WAIT exit target: HALTED if halt_pending set, else HALTED if step_return set (and pulse step_done), else RUN.
REQ-023 dbg_halt_req during MEM_WAIT sets halt_pending; the memory access is never aborted.
REQ-024 HALTED: dbg_resume_req -> RUN, clears wfi_wait; dbg_step_req -> STEP, load step counter = STEP_CYCLES; resume and step in the same cycle: resume wins.
REQ-025 HALTED with wfi_wait=1 and irq_pending=1 -> RUN, clears wfi_wait; a debug halt (dbg_halt_req) while wfi_wait=1 clears wfi_wait, so only resume exits.
REQ-026 STEP: step counter decrements per cycle; at 0 -> HALTED with step_done=1 for exactly one cycle.
REQ-027 mem_req in STEP -> MEM_WAIT with step_return set; the step counter is abandoned.
REQ-028 dbg_halt_req, core_wfi, dbg_step_req and dbg_resume_req in STEP are ignored.
REQ-029 dbg_halt_req, dbg_step_req and core_wfi in HALTED are ignored; dbg_resume_req in RUN, MEM_WAIT or STEP is ignored.
REQ-030 halt_pending and step_return clear on MEM_WAIT exit.
REQ-031 Counters are 4 bits and never wrap below 0.

Reset
REQ-032 reset_n=0 asynchronously forces state=RUN, halt=0, halted=0, step_done=0, counters=0, and clears wfi_wait, halt_pending and step_return.
REQ-033 Reset asserted mid-MEM_WAIT or mid-STEP abandons the operation; the first posedge after reset_n deassertion evaluates RUN rules.

Verification
REQ-034 Reset deassert, then mem_req pulse with WAIT_CYCLES=2 -> halt=1 for exactly 2 cycles, state 01 then 00.
REQ-035 mem_req, then mem_ready on the next cycle with WAIT_CYCLES=4 -> halt=1 for 1 cycle only, then RUN.
REQ-036 dbg_halt_req during MEM_WAIT -> stall completes, then halted=1 and halt stays 1 until dbg_resume_req, then halt=0 on the next posedge.
REQ-037 From HALTED, dbg_step_req with STEP_CYCLES=1 -> halt=0 for 1 cycle, then halted=1 with step_done=1 for one cycle; dbg_step_req and dbg_resume_req together -> RUN, step_done stays 0.
REQ-038 core_wfi with irq_pending=0 -> HALTED; irq_pending=1 three cycles later -> RUN on the next posedge; core_wfi with irq_pending=1 -> stays RUN.
REQ-039 reset_n pulsed low in MEM_WAIT -> halt=0 and state=00 immediately, without waiting for a clock edge.
